// File: rtl/fb_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fb_fill_ctrl
//  Description : Framebuffer write-port arbiter between direct CPU pixel
//                writes and a clipped rectangle-fill engine. CPU writes
//                always win; the fill cursor stalls while the CPU owns
//                the port.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_fill_ctrl #(
  parameter int FB_W = 80,
  parameter int FB_H = 60
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_we_i,
  input  logic [12:0] cpu_wa_i,
  input  logic [7:0]  cpu_wd_i,
  input  logic        cmd_we_i,
  input  logic [2:0]  cmd_sel_i,
  input  logic [7:0]  cmd_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fb_we_o,
  output logic [12:0] fb_wa_o,
  output logic [7:0]  fb_wd_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam logic [2:0]  c_sel_x0    = 3'd0;
  localparam logic [2:0]  c_sel_y0    = 3'd1;
  localparam logic [2:0]  c_sel_w     = 3'd2;
  localparam logic [2:0]  c_sel_h     = 3'd3;
  localparam logic [2:0]  c_sel_color = 3'd4;
  localparam logic [2:0]  c_sel_start = 3'd5;
  localparam logic [2:0]  c_sel_abort = 3'd6;
  localparam logic [8:0]  c_fb_w9     = 9'(FB_W);
  localparam logic [8:0]  c_fb_h9     = 9'(FB_H);
  localparam logic [12:0] c_row_step  = 13'(FB_W);

  state_e      state_q, state_d;
  logic [7:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d, color_q, color_d;
  logic [8:0]  xe_q, xe_d, ye_q, ye_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [12:0] base_q, base_d;
  logic        fb_we_q, fb_we_d;
  logic [12:0] fb_wa_q, fb_wa_d;
  logic [7:0]  fb_wd_q, fb_wd_d;
  logic        done_q, done_d;

  // Clipped bounds use 9-bit sums so X0+W / Y0+H can never wrap.
  logic [8:0]  w_x_sum, w_y_sum, w_xe, w_ye, w_x_next, w_y_next;
  logic [12:0] w_row_base0;
  logic        w_degen, w_start, w_abort;

  assign w_x_sum  = {1'b0, x0_q} + {1'b0, w_q};
  assign w_y_sum  = {1'b0, y0_q} + {1'b0, h_q};
  assign w_xe     = (w_x_sum > c_fb_w9) ? c_fb_w9 : w_x_sum;
  assign w_ye     = (w_y_sum > c_fb_h9) ? c_fb_h9 : w_y_sum;
  assign w_degen  = ({1'b0, x0_q} >= c_fb_w9) || ({1'b0, y0_q} >= c_fb_h9) ||
                    (w_q == 8'd0) || (h_q == 8'd0);
  assign w_x_next = {1'b0, x_q} + 9'd1;
  assign w_y_next = {1'b0, y_q} + 9'd1;
  // Starting row base only: a multiply by the constant FB_W (shift-add).
  // Per-pixel addresses afterwards come from the incrementally kept base.
  assign w_row_base0 = {5'b0, y0_q} * c_row_step;
  assign w_start  = cmd_we_i && (cmd_sel_i == c_sel_start);
  assign w_abort  = cmd_we_i && (cmd_sel_i == c_sel_abort);

  // State, register file, cursor and registered write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      fb_we_q <= 1'b0;
      fb_wa_q <= '0;
      fb_wd_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      fb_we_q <= fb_we_d;
      fb_wa_q <= fb_wa_d;
      fb_wd_q <= fb_wd_d;
      done_q  <= done_d;
    end
  end

  // Next-state: command decode, fill stepping, CPU priority on the port.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    fb_we_d = 1'b0;
    fb_wa_d = fb_wa_q;
    fb_wd_d = fb_wd_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_we_i) begin
          case (cmd_sel_i)
            c_sel_x0:    x0_d    = cmd_data_i;
            c_sel_y0:    y0_d    = cmd_data_i;
            c_sel_w:     w_d     = cmd_data_i;
            c_sel_h:     h_d     = cmd_data_i;
            c_sel_color: color_d = cmd_data_i;
            default: ;
          endcase
        end
        if (w_start) begin
          if (w_degen) begin
            done_d = 1'b1;
          end else begin
            state_d = FILL;
            xe_d    = w_xe;
            ye_d    = w_ye;
            x_d     = x0_q;
            y_d     = y0_q;
            base_d  = w_row_base0;
          end
        end
      end
      FILL: begin
        if (w_abort) begin
          state_d = IDLE;
        end else if (!cpu_we_i) begin
          fb_we_d = 1'b1;
          fb_wa_d = base_q + {5'b0, x_q};
          fb_wd_d = color_q;
          if (w_x_next == xe_q) begin
            x_d    = x0_q;
            y_d    = w_y_next[7:0];
            base_d = base_q + c_row_step;
            if (w_y_next == ye_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            x_d = w_x_next[7:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The CPU always owns the port in its cycle; the fill above has stalled.
    if (cpu_we_i) begin
      fb_we_d = 1'b1;
      fb_wa_d = cpu_wa_i;
      fb_wd_d = cpu_wd_i;
    end
  end

  assign busy_o  = (state_q == FILL);
  assign done_o  = done_q;
  assign fb_we_o = fb_we_q;
  assign fb_wa_o = fb_wa_q;
  assign fb_wd_o = fb_wd_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_fill_ctrl
//  Description : Self-checking bench for fb_fill_ctrl: table of rectangle
//                fills plus hand-written CPU-contention, abort and reset
//                sequences; every framebuffer write is matched against a
//                queue of expected writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_fill_ctrl;
  localparam int FB_W = 80;
  localparam int FB_H = 60;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [12:0] cpu_wa_i = '0;
  logic [7:0]  cpu_wd_i = '0;
  logic        cmd_we_i = 1'b0;
  logic [2:0]  cmd_sel_i = '0;
  logic [7:0]  cmd_data_i = '0;
  logic        busy_o, done_o, fb_we_o;
  logic [12:0] fb_wa_o;
  logic [7:0]  fb_wd_o;

  fb_fill_ctrl #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_we_i(cpu_we_i), .cpu_wa_i(cpu_wa_i), .cpu_wd_i(cpu_wd_i),
    .cmd_we_i(cmd_we_i), .cmd_sel_i(cmd_sel_i), .cmd_data_i(cmd_data_i),
    .busy_o(busy_o), .done_o(done_o),
    .fb_we_o(fb_we_o), .fb_wa_o(fb_wa_o), .fb_wd_o(fb_wd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    int x0, y0, w, h, color;
    int npix;
  } vec_t;

  wr_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wcount = 0;
  int  done_cnt = 0;

  // Scoreboard: every observed write must match the head of the queue.
  always @(negedge clk_i) begin
    if (rst_ni && fb_we_o) begin
      wcount++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: unexpected write addr=%0d data=%0h", fb_wa_o, fb_wd_o);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        if (fb_wa_o !== e.a || fb_wd_o !== e.d) begin
          errors++;
          $display("FAIL sb_write: got addr=%0d data=%0h expected addr=%0d data=%0h",
                   fb_wa_o, fb_wd_o, e.a, e.d);
        end
      end
    end
    if (rst_ni && done_o) done_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] sel, input logic [7:0] data);
    cmd_we_i = 1'b1; cmd_sel_i = sel; cmd_data_i = data;
    tick();
    cmd_we_i = 1'b0; cmd_sel_i = '0; cmd_data_i = '0;
  endtask

  task automatic program_rect(input int x0, input int y0, input int w, input int h, input int c);
    cmd(3'd0, 8'(x0)); cmd(3'd1, 8'(y0)); cmd(3'd2, 8'(w));
    cmd(3'd3, 8'(h));  cmd(3'd4, 8'(c));
  endtask

  // Reference model: clipped row-major pixel list, optionally truncated.
  task automatic push_rect(input int x0, input int y0, input int w, input int h,
                           input int c, input int limit);
    int xe, ye, n;
    wr_t e;
    xe = (x0 + w > FB_W) ? FB_W : x0 + w;
    ye = (y0 + h > FB_H) ? FB_H : y0 + h;
    n = 0;
    if (x0 < FB_W && y0 < FB_H && w != 0 && h != 0)
      for (int y = y0; y < ye; y++)
        for (int x = x0; x < xe; x++)
          if (n < limit) begin
            e.a = 13'(y * FB_W + x); e.d = 8'(c);
            sb_q.push_back(e);
            n++;
          end
  endtask

  task automatic push_one(input int a, input int d);
    wr_t e;
    e.a = 13'(a); e.d = 8'(d);
    sb_q.push_back(e);
  endtask

  // off = cycles since START was sampled; bounded wait for DONE.
  task automatic wait_done(inout int off);
    while (!done_o && off < 6000) begin
      tick();
      off++;
    end
  endtask

  vec_t tbl[10];

  initial begin
    int off;
    tbl[0] = '{2, 3, 3, 2, 8'hE0, 6};
    tbl[1] = '{78, 59, 10, 10, 8'h55, 2};
    tbl[2] = '{0, 0, 0, 5, 8'h11, 0};
    tbl[3] = '{80, 0, 3, 3, 8'h22, 0};
    tbl[4] = '{0, 60, 2, 2, 8'h33, 0};
    tbl[5] = '{5, 5, 4, 0, 8'h44, 0};
    tbl[6] = '{0, 0, 1, 1, 8'hFF, 1};
    tbl[7] = '{76, 10, 8, 3, 8'h0F, 12};
    tbl[8] = '{200, 200, 255, 255, 8'h01, 0};
    tbl[9] = '{10, 50, 255, 255, 8'h07, 700};

    // Reset state, with a CPU write attempted while reset is held.
    cpu_we_i = 1'b1; cpu_wa_i = 13'd5; cpu_wd_i = 8'h5;
    tick(); tick();
    check("rst_we", fb_we_o, 0);
    check("rst_wa", fb_wa_o, 0);
    check("rst_wd", fb_wd_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    cpu_we_i = 1'b0;
    rst_ni = 1'b1;
    tick();

    // Direct CPU write while idle.
    wcount = 0;
    push_one(4799, 8'hAA);
    cpu_we_i = 1'b1; cpu_wa_i = 13'd4799; cpu_wd_i = 8'hAA;
    tick();
    cpu_we_i = 1'b0;
    tick(); tick();
    check("idle_cpu_cnt", wcount, 1);

    // Table-driven fills.
    foreach (tbl[i]) begin
      wcount = 0; done_cnt = 0;
      program_rect(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].color);
      push_rect(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].color, 1 << 30);
      cmd(3'd5, 8'd0);
      off = 1;
      check("busy_n1", busy_o, (tbl[i].npix > 0) ? 1 : 0);
      wait_done(off);
      check("done_lat", off, (tbl[i].npix == 0) ? 1 : tbl[i].npix + 1);
      tick();
      check("busy_after", busy_o, 0);
      check("done_pulse", done_o, 0);
      check("npix", wcount, tbl[i].npix);
      check("sb_empty", sb_q.size(), 0);
    end

    // CPU write interleaved into a 4x1 fill.
    wcount = 0;
    program_rect(0, 0, 4, 1, 8'h5A);
    push_one(0, 8'h5A); push_one(1000, 8'h1C);
    push_one(1, 8'h5A); push_one(2, 8'h5A); push_one(3, 8'h5A);
    cmd(3'd5, 8'd0);
    tick();
    cpu_we_i = 1'b1; cpu_wa_i = 13'd1000; cpu_wd_i = 8'h1C;
    tick();
    cpu_we_i = 1'b0;
    off = 3;
    wait_done(off);
    check("cpu_done_lat", off, 6);
    tick();
    check("cpu_cnt", wcount, 5);
    check("cpu_sb_empty", sb_q.size(), 0);

    // Full fill aborted after 100 writes; register write and START ignored mid-fill.
    wcount = 0; done_cnt = 0;
    program_rect(0, 0, 80, 60, 8'h3C);
    push_rect(0, 0, 80, 60, 8'h3C, 100);
    cmd(3'd5, 8'd0);
    repeat (9) tick();
    cmd(3'd4, 8'h99);
    cmd(3'd5, 8'd0);
    repeat (89) tick();
    cmd(3'd6, 8'd0);
    repeat (10) tick();
    check("abort_cnt", wcount, 100);
    check("abort_done", done_cnt, 0);
    check("abort_busy", busy_o, 0);
    check("abort_sb_empty", sb_q.size(), 0);
    cmd(3'd6, 8'd0);
    program_rect(1, 1, 2, 1, 8'h42);
    push_rect(1, 1, 2, 1, 8'h42, 1 << 30);
    cmd(3'd5, 8'd0);
    off = 1;
    wait_done(off);
    check("restart_done_lat", off, 3);
    tick();
    check("restart_cnt", wcount, 102);

    // Reset asserted mid-fill after 50 writes.
    wcount = 0; done_cnt = 0;
    program_rect(0, 0, 80, 60, 8'h77);
    push_rect(0, 0, 80, 60, 8'h77, 50);
    cmd(3'd5, 8'd0);
    repeat (51) tick();
    rst_ni = 1'b0;
    #1;
    check("mid_rst_we", fb_we_o, 0);
    check("mid_rst_wa", fb_wa_o, 0);
    check("mid_rst_wd", fb_wd_o, 0);
    check("mid_rst_busy", busy_o, 0);
    repeat (3) tick();
    rst_ni = 1'b1;
    repeat (10) tick();
    check("mid_rst_cnt", wcount, 50);
    check("mid_rst_done", done_cnt, 0);
    check("mid_rst_sb_empty", sb_q.size(), 0);
    // Registers were cleared, so W==0 makes START degenerate.
    cmd(3'd5, 8'd0);
    check("post_rst_done", done_o, 1);
    check("post_rst_busy", busy_o, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_fill_ctrl.md
FB_FILL_CTRL -- requirements
Module: fb_fill_ctrl

Interface
REQ-001 Parameter FB_W, default 80, framebuffer width in pixels.
REQ-002 Parameter FB_H, default 60, framebuffer height in pixels.
REQ-003 CLK  in  1  system clock (50 MHz CPU domain); all state updates on rising edge.
REQ-004 RST_N  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 CPU_WE  in  1  direct CPU pixel write request, single-cycle.
REQ-006 CPU_WA  in  13  direct write address (y*FB_W+x).
REQ-007 CPU_WD  in  8  direct write colour.
REQ-008 CMD_WE  in  1  command register write strobe.
REQ-009 CMD_SEL  in  3  register select: 0 X0, 1 Y0, 2 W, 3 H, 4 COLOR, 5 START, 6 ABORT, 7 reserved (ignored).
REQ-010 CMD_DATA  in  8  command register data.
REQ-011 BUSY  out  1  fill in progress (state FILL).
REQ-012 DONE  out  1  one-cycle pulse on fill completion.
REQ-013 FB_WE  out  1  framebuffer write enable, registered.
REQ-014 FB_WA  out  13  framebuffer address, registered.
REQ-015 FB_WD  out  8  framebuffer colour, registered.

Function
REQ-016 The block SHALL arbitrate one framebuffer write port between direct CPU writes and a rectangle-fill engine; CPU_WE always wins.
REQ-017 States SHALL be IDLE and FILL; BUSY = (state==FILL).
REQ-018 CMD_WE with CMD_SEL 0-4 SHALL load X0/Y0/W/H/COLOR only in IDLE; ignored in FILL.
REQ-019 START (CMD_SEL 5) in IDLE SHALL compute clipped bounds XE=min(X0+W,FB_W), YE=min(Y0+H,FB_H) using 9-bit sums (no wrap); START in FILL ignored.
REQ-020 If X0>=FB_W, Y0>=FB_H, W==0 or H==0, START SHALL stay in IDLE, issue no writes, and pulse DONE in the next cycle.
REQ-021 Otherwise START sampled in cycle N SHALL enter FILL at N+1 with cursor (x,y)=(X0,Y0).
REQ-022 Each FILL cycle without CPU_WE SHALL register FB_WE=1, FB_WA=y*FB_W+x, FB_WD=COLOR, then advance x; at x+1==XE, x<=X0 and y<=y+1.
REQ-023 FB_WA SHALL be generated with an incrementally maintained row base (add FB_W per row), no multiplier.
REQ-024 Any cycle with CPU_WE=1 SHALL register FB_WE=1, FB_WA=CPU_WA, FB_WD=CPU_WD; the fill cursor holds that cycle, no pixel dropped or duplicated.
REQ-025 Pixel order SHALL be row-major, top-left to bottom-right.
REQ-026 Issuing the last pixel (x+1==XE, y+1==YE) SHALL return to IDLE; DONE SHALL be high in the same cycle as the last FB_WE.
REQ-027 Without CPU contention, npix=(XE-X0)*(YE-Y0) writes SHALL appear in cycles N+2..N+1+npix.
REQ-028 ABORT (CMD_SEL 5 and 6 never coincide) in FILL SHALL return to IDLE at the next edge, issue no further fill writes, and not pulse DONE; a CPU write in that cycle still passes.
REQ-029 ABORT in IDLE SHALL be ignored.
REQ-030 FB_WE SHALL be 0 in any cycle with no CPU write and no fill pixel.

Reset
REQ-031 RST_N low SHALL asynchronously force state IDLE, BUSY=0, DONE=0, FB_WE=0, FB_WA=0, FB_WD=0, X0=Y0=W=H=COLOR=0.
REQ-032 RST_N low mid-fill SHALL abandon the fill with no further writes and no DONE; deassertion takes effect on the next rising CLK.

Verification
REQ-033 X0=2,Y0=3,W=3,H=2,COLOR=0xE0, START at N -> FB_WA 242,243,244,322,323,324 in N+2..N+7, DONE at N+7, BUSY low N+8.
REQ-034 X0=78,Y0=59,W=10,H=10, START -> writes only 4798,4799; DONE with second write.
REQ-035 Fill 4x1 at (0,0), CPU_WE with CPU_WA=1000,CPU_WD=0x1C in N+2 -> sequence 0,1000,1,2,3; DONE at N+6.
REQ-036 W=0 START -> no FB_WE, DONE pulse at N+1, BUSY never high; X0=80 START -> same.
REQ-037 80x60 full fill, ABORT after 100 writes -> exactly 100 or 101 writes (per REQ-028 timing), no DONE; START next accepted.
REQ-038 RST_N low at 50th write of full fill -> outputs zero immediately, no writes after release until new START.
